// File: rtl/modulo_mef_controle_registrador_pkg.sv
// Shared state encodings and width helper for the register-feed controller.
package modulo_mef_controle_registrador_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD    = 2'b01,
        VALID   = 2'b11,
        RELEASE = 2'b10
    } state_t;

    // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/modulo_fifo_registrador.sv
// Small FIFO of operator-entered values; occupancy counter decides full/empty.
// Latency: a pushed entry is visible at head the cycle after the push when the FIFO was empty.
// Backpressure: a push while full is dropped silently; a pop on an empty FIFO is ignored.
module modulo_fifo_registrador
    import modulo_mef_controle_registrador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                data_in,
    output logic [WIDTH-1:0]                head,
    output logic                            full,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the pre-update count, so a push may land in the same cycle as a pop.
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/modulo_mef_controle_registrador.sv
// Producer-side FSM: queues button-entered values and presents the head to the counter FSM.
// Latency: press sampled at cycle 0 -> Load_Reg with the value at cycle 3; 3 idle cycles between values.
// Backpressure: holds each value until Clear_Reg; presses while Full are dropped; enable=0 freezes all.
module modulo_mef_controle_registrador
    import modulo_mef_controle_registrador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            wr_btn,
    input  logic [WIDTH-1:0]                data_in,
    input  logic                            Clear_Reg,
    output logic [WIDTH-1:0]                Reg_out,
    output logic                            Load_Reg,
    output logic                            EmptyBuffer,
    output logic                            Full,
    output logic [count_width(DEPTH)-1:0]   count
);

    localparam int CW = count_width(DEPTH);

    state_t           state;
    logic             btn_prev;
    logic             push_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic [WIDTH-1:0] fifo_head;

    assign push_req  = wr_btn & ~btn_prev;
    assign fifo_push = enable & push_req;
    assign fifo_pop  = enable & (state == VALID) & Clear_Reg;

    modulo_fifo_registrador #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .data_in (data_in),
        .head    (fifo_head),
        .full    (Full),
        .count   (count)
    );

    // btn_prev resets high so a button held through reset release is not taken as a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            btn_prev <= 1'b1;
            Reg_out  <= '0;
        end else if (enable) begin
            btn_prev <= wr_btn;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    Reg_out <= fifo_head;
                    state   <= VALID;
                end
                VALID: begin
                    if (Clear_Reg) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // While a value is presented it still occupies the FIFO, hence the count==1 test in VALID.
    assign Load_Reg    = (state == VALID);
    assign EmptyBuffer = (state == VALID) ? (count == CW'(1)) : (count == '0);

endmodule

// File: doc/modulo_mef_controle_registrador.md
Name: modulo_mef_controle_registrador

Overview:
- Producer-side control FSM that feeds the counter's control FSM.
- Captures operator-entered values (data_in latched on each wr_btn press) into a small FIFO.
- Presents the FIFO head on Reg_out with Load_Reg high and reports EmptyBuffer, meaning "nothing queued behind the presented value".
- Pops the head when the counter FSM returns its one-cycle Clear_Reg acknowledge.

Parameters:
- WIDTH, 4: bit width of each stored value and of Reg_out.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  global advance enable; when low, all state holds.
- wr_btn  input  1  synchronised button level; a push happens on its rising edge.
- data_in  input  WIDTH  value captured at the wr_btn rising edge.
- Clear_Reg  input  1  consumer acknowledge; one-cycle pulse, meaningful only while Load_Reg=1.
- Reg_out  output  WIDTH  registered copy of the FIFO head being presented.
- Load_Reg  output  1  Reg_out holds a valid, unconsumed value.
- EmptyBuffer  output  1  no entries queued beyond the presented one.
- Full  output  1  FIFO holds DEPTH entries.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state IDLE, rd/wr pointers 0, count 0, Reg_out 0;
  - Load_Reg 0, EmptyBuffer 1, Full 0;
  - btn_prev 1, so a button held through reset release does not cause a push.
- enable=0 freezes the FSM, FIFO, pointers, Reg_out and btn_prev. Outputs keep their values. Reset still wins.
- Edge detect: push_req = wr_btn & ~btn_prev. btn_prev <= wr_btn every enabled cycle.
- Push: when push_req & ~Full, write data_in at wr_ptr, increment wr_ptr (mod DEPTH), count+1. When push_req & Full, drop the request silently; FIFO and count are unchanged.
- FSM, 2-bit encoded:
  - IDLE (Load_Reg=0): go to LOAD if count>0, else stay.
  - LOAD (Load_Reg=0): Reg_out <= fifo[rd_ptr]; go to VALID unconditionally. Lasts one cycle.
  - VALID (Load_Reg=1): Reg_out is stable. On Clear_Reg: pop (rd_ptr+1 mod DEPTH, count-1), go to RELEASE. Otherwise stay.
  - RELEASE (Load_Reg=0): one-cycle gap so the consumer sees Load_Reg fall; go to IDLE.
- Load_Reg is decoded from state only (VALID), so it is glitch-free.
- EmptyBuffer is combinational: (count==1) in VALID, (count==0) in every other state.
- Full = (count==DEPTH).
- Latency, from IDLE with an empty FIFO:
  - cycle 0: wr_btn first sampled high;
  - cycle 1: count=1;
  - cycle 2: LOAD;
  - cycle 3: Load_Reg=1 with Reg_out=data_in from cycle 0.
- Back-to-back consumption: after Clear_Reg in VALID the sequence is RELEASE, IDLE, LOAD, VALID. This gives 3 cycles of Load_Reg=0 between consecutive presented values.
- Simultaneous push and pop in VALID: both execute, count unchanged. The new entry lands at wr_ptr and does not disturb Reg_out.
- Push when count==DEPTH-1 during a pop cycle: allowed, because Full is evaluated on the pre-update count.
- Clear_Reg outside VALID: ignored, no pop.
- Pointer wrap: both pointers wrap modulo DEPTH. count, not pointer comparison, decides full/empty.
- Reset mid-handshake (in VALID): Load_Reg drops immediately (asynchronous), queued data is discarded, Reg_out=0.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'b00, LOAD=2'b01, VALID=2'b11, RELEASE=2'b10;
  - a width helper for count (clog2(DEPTH)+1).
- One sub-module, modulo_fifo_registrador (WIDTH, DEPTH), owns:
  - storage, pointers, count, Full;
  - push and pop inputs with the full/drop rule.
- The FSM, edge detect and Reg_out register stay in the top.

Test Plan:
- Reset with wr_btn=1, then release rst, hold wr_btn=1 for 5 cycles -> no push: count=0, Load_Reg=0, EmptyBuffer=1.
- Single press with data_in=4'h9 at cycle 0 -> Load_Reg=1 at cycle 3, Reg_out=4'h9, EmptyBuffer=1. Then Clear_Reg pulse -> Load_Reg=0 the next cycle, count=0.
- Press 4'h1, 4'h2, 4'h3, no acknowledge -> Reg_out=4'h1, EmptyBuffer=0, count=3. Acknowledge each -> Reg_out sequence 1, 2, 3 with Load_Reg low for exactly 3 cycles between values; EmptyBuffer=1 while 4'h3 is presented.
- Five presses with DEPTH=4 and no acknowledge -> Full=1, count=4, fifth value dropped. After draining, exactly the first four values are observed in order.
- Push coinciding with Clear_Reg in VALID at count=2 -> count stays 2; order is preserved across pointer wrap (run 10 values through).
- enable=0 for 4 cycles while in VALID, with a Clear_Reg pulse and a press during the freeze -> nothing changes. Then assert rst=0 mid-VALID -> Load_Reg=0 and Reg_out=0 without waiting for a clock edge.
